// File: rtl/modred_pkg.sv
// Shared types and helpers for the sequential Barrett reducer.
package modred_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_SUB,
        S_CORR,
        S_DONE
    } modred_state_t;

    // Datapath widths for the default LOGQ=60 build; instances derive their own from LOGQ.
    localparam int unsigned LOGQ_DEF = 60;
    localparam int unsigned K1       = LOGQ_DEF + 1;
    localparam int unsigned PW       = 2 * LOGQ_DEF + 2;

    // Edges from accept to the first out_valid cycle.
    function automatic int unsigned modred_lat(input int unsigned mul_lat, input int unsigned ncorr);
        return 2 * mul_lat + ncorr + 2;
    endfunction

endpackage

// File: rtl/modred_barrett_seq_mul_pipe.sv
// Unsigned WA x WB multiplier followed by LAT register stages; data path carries no reset.
module mul_pipe #(
    parameter int unsigned WA  = 61,
    parameter int unsigned WB  = 61,
    parameter int unsigned LAT = 2
) (
    input  logic               clk,
    input  logic [WA-1:0]      a,
    input  logic [WB-1:0]      b,
    output logic [WA+WB-1:0]   p
);

    localparam int unsigned WP = WA + WB;

    logic [WP-1:0] stg [LAT];

    always_ff @(posedge clk) begin
        stg[0] <= WP'(a) * WP'(b);
        for (int unsigned i = 1; i < LAT; i++) begin
            stg[i] <= stg[i-1];
        end
    end

    assign p = stg[LAT-1];

endmodule

// File: rtl/modred_barrett_seq.sv
// Sequential Barrett reducer: r = C mod Q using one time-shared pipelined multiplier.
module modred_barrett_seq
    import modred_pkg::*;
#(
    parameter int unsigned LOGQ    = 60,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*LOGQ-1:0]   in_c,
    input  logic [LOGQ-1:0]     q,
    input  logic [LOGQ:0]       mu,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LOGQ-1:0]     out_r,
    output logic                busy
);

    localparam int unsigned KW = LOGQ + 1;
    localparam int unsigned WP = 2 * LOGQ + 2;
    localparam int unsigned CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);

    modred_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [KW-1:0] c_lo, p_lo, r, q_ext, q3, mul_a, mul_b;
    logic [WP-1:0] mul_p;
    logic          rdy, cnt_zero, r_ge_q;

    assign q_ext    = {1'b0, q};
    assign q3       = mul_p[WP-1:KW];
    assign cnt_zero = (cnt == '0);
    assign r_ge_q   = (r >= q_ext);

    mul_pipe #(
        .WA  (KW),
        .WB  (KW),
        .LAT (MUL_LAT)
    ) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    // Operands are issued one cycle ahead: IDLE feeds the live input, and the last
    // MUL1 cycle feeds q3 straight off the multiplier output into the q*Q product.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mul_a     = in_c[2*LOGQ-1:LOGQ-1];
        mul_b     = mu;
        unique case (state)
            S_IDLE: begin
                if (in_valid && rdy) begin
                    state_nxt = S_MUL1;
                    cnt_nxt   = CNT_INIT;
                end
            end
            S_MUL1: begin
                mul_a = q3;
                mul_b = q_ext;
                if (cnt_zero) begin
                    state_nxt = S_MUL2;
                    cnt_nxt   = CNT_INIT;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_MUL2: begin
                if (cnt_zero) state_nxt = S_SUB;
                else          cnt_nxt   = cnt - CW'(1);
            end
            S_SUB:  state_nxt = S_CORR;
            S_CORR: if (!r_ge_q) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            rdy   <= 1'b0;
            c_lo  <= '0;
            p_lo  <= '0;
            r     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rdy   <= (state_nxt == S_IDLE);
            if (state == S_IDLE && in_valid && rdy) c_lo <= in_c[KW-1:0];
            if (state == S_MUL2 && cnt_zero)        p_lo <= mul_p[KW-1:0];
            if (state == S_SUB)                     r    <= c_lo - p_lo;
            else if (state == S_CORR && r_ge_q)     r    <= r - q_ext;
        end
    end

    assign in_ready  = rdy;
    assign out_valid = (state == S_DONE);
    assign out_r     = r[LOGQ-1:0];
    assign busy      = (state != S_IDLE);

endmodule
